// File: rtl/report_collector.sv
// rtl/report_collector.sv - tags automaton reports with symbol offsets, queues them and appends an end marker
module report_collector #(
  parameter int NUM_REPORTS = 2,
  parameter int OFFSET_W    = 32,
  parameter int DEPTH       = 16,
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   eos,
  input  logic [NUM_REPORTS-1:0] report_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFFSET_W-1:0]    out_offset,
  output logic [NUM_REPORTS-1:0] out_vector,
  output logic                   out_last,
  output logic                   overflow,
  output logic [DROP_W-1:0]      dropped,
  output logic                   busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = OFFSET_W + NUM_REPORTS + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

  state_t               state;
  logic                 run_q;
  logic [OFFSET_W-1:0]  off_cnt;
  logic [OFFSET_W-1:0]  off_q;
  logic [OFFSET_W-1:0]  cur_off;
  logic [REC_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          count;
  logic                 gen;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [REC_W-1:0]     push_rec;
  logic [REC_W-1:0]     head;

  // A new stream started from DONE numbers its first symbol 0 again.
  always_comb begin
    cur_off  = (state == DONE) ? '0 : off_cnt;
    gen      = (state == ACTIVE) && run_q && (|report_in);
    full     = (count == (AW+1)'(DEPTH));
    pop      = out_valid && out_ready;
    push     = (gen || (state == FLUSH)) && (!full || pop);
    drop     = gen && full && !pop;
    push_rec = (state == FLUSH) ? {off_cnt, {NUM_REPORTS{1'b0}}, 1'b1}
                                : {off_q, report_in, 1'b0};
  end

  assign head       = mem[rptr];
  assign out_valid  = (count != '0);
  assign out_offset = out_valid ? head[REC_W-1 -: OFFSET_W] : '0;
  assign out_vector = out_valid ? head[NUM_REPORTS:1] : '0;
  assign out_last   = out_valid ? head[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset && push) mem[wptr] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      run_q    <= 1'b0;
      off_cnt  <= '0;
      off_q    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      run_q <= run;
      if (run) begin
        off_q   <= cur_off;
        off_cnt <= cur_off + 1'b1;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 1'b1;
      end
      // The end marker is only ever pushed, never dropped; FLUSH simply retries.
      case (state)
        IDLE:    if (run)  begin state <= ACTIVE; busy <= 1'b1; end
        ACTIVE:  if (eos)  state <= FLUSH;
        FLUSH:   if (push) begin state <= DONE; busy <= 1'b0; end
        DONE:    if (run)  begin state <= ACTIVE; busy <= 1'b1; end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase
    end
  end

endmodule

// File: tb/tb_report_collector.sv
// tb/tb_report_collector.sv - directed self-checking bench for report_collector
module tb_report_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        eos;
  logic [1:0]  report_in;
  logic        out_ready;
  logic        out_ready2;
  logic        out_valid,  out_valid2;
  logic [31:0] out_offset;
  logic [3:0]  out_offset2;
  logic [1:0]  out_vector, out_vector2;
  logic        out_last,   out_last2;
  logic        overflow,   overflow2;
  logic [15:0] dropped,    dropped2;
  logic        busy,       busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_err = 0;
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic        hold_q = 1'b0;
  logic [63:0] hold_rec = '0;
  logic [63:0] cur1;

  always #5 clk = ~clk;

  report_collector dut (
    .clk(clk), .reset(reset), .run(run), .eos(eos), .report_in(report_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
    .out_vector(out_vector), .out_last(out_last), .overflow(overflow),
    .dropped(dropped), .busy(busy)
  );

  report_collector #(.OFFSET_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .run(run), .eos(eos), .report_in(report_in),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_offset(out_offset2),
    .out_vector(out_vector2), .out_last(out_last2), .overflow(overflow2),
    .dropped(dropped2), .busy(busy2)
  );

  // Collect accepted records and flag any head change while stalled.
  always @(negedge clk) begin
    cur1 = {29'b0, out_offset, out_vector, out_last};
    if (hold_q && cur1 != hold_rec) stall_err++;
    hold_q   = out_valid && !out_ready && reset;
    hold_rec = cur1;
    if (reset && out_valid && out_ready)   q1.push_back(cur1);
    if (reset && out_valid2 && out_ready2) q2.push_back({57'b0, out_offset2, out_vector2, out_last2});
  end

  function automatic logic [63:0] mk(input logic [31:0] off, input logic [1:0] vec, input logic last);
    return {29'b0, off, vec, last};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ready_k: -1 leave out_ready alone, -2 toggle every cycle, >=0 pulse ready in that cycle only
  task automatic stream(input int n, input logic [1:0] pat, input int lo, input int hi,
                        input bit do_eos, input int ready_k);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      run       = (k < n);
      report_in = (k >= 1 && k - 1 >= lo && k - 1 <= hi) ? pat : 2'b00;
      eos       = do_eos && (k == n);
      if (ready_k == -2)     out_ready = k[0];
      else if (ready_k >= 0) out_ready = (k == ready_k);
    end
    @(posedge clk); #1;
    run = 1'b0; report_in = 2'b00; eos = 1'b0;
    if (ready_k == -2) out_ready = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && !out_valid) break;
      @(posedge clk); #1;
    end
    if (i >= budget) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; eos = 1'b0; report_in = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int b;
    int sb;
    reset = 1'b0; run = 1'b0; eos = 1'b0; report_in = 2'b00;
    out_ready = 1'b0; out_ready2 = 1'b1;
    tick(2);
    reset = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    check("rst_overflow", overflow, 0);
    check("rst_offset", out_offset, 0);
    check("rst_last", out_last, 0);
    check("rst_vector", out_vector, 0);

    // single report at offset 3 in a 5-symbol stream
    out_ready = 1'b1;
    b = q1.size();
    stream(5, 2'b01, 3, 3, 1'b1, -1);
    wait_idle(50);
    check("t1_count", q1.size() - b, 2);
    if (q1.size() - b >= 2) begin
      check("t1_rec", q1[b], mk(3, 2'b01, 0));
      check("t1_marker", q1[b+1], mk(5, 2'b00, 1));
    end
    check("t1_overflow", overflow, 0);

    // 20 records into a stalled 16-deep FIFO
    out_ready = 1'b0;
    b = q1.size();
    stream(20, 2'b11, 0, 19, 1'b1, -1);
    tick(3);
    check("t2_busy_flush", busy, 1);
    check("t2_valid", out_valid, 1);
    check("t2_dropped", dropped, 4);
    check("t2_overflow", overflow, 1);
    check("t2_none_yet", q1.size() - b, 0);
    out_ready = 1'b1;
    wait_idle(100);
    check("t2_count", q1.size() - b, 17);
    if (q1.size() - b >= 17) begin
      for (int i = 0; i < 16; i++) check("t2_rec", q1[b+i], mk(i, 2'b11, 0));
      check("t2_marker", q1[b+16], mk(20, 2'b00, 1));
    end

    // reset mid-stream with records queued, then a fresh stream
    out_ready = 1'b0;
    stream(3, 2'b01, 0, 2, 1'b0, -1);
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_busy", busy, 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("t5_valid", out_valid, 0);
    check("t5_dropped", dropped, 0);
    check("t5_busy", busy, 0);
    check("t5_overflow", overflow, 0);
    out_ready = 1'b1;
    b = q1.size();
    stream(2, 2'b01, 0, 0, 1'b1, -1);
    wait_idle(50);
    check("t5_count", q1.size() - b, 2);
    if (q1.size() - b >= 2) begin
      check("t5_rec", q1[b], mk(0, 2'b01, 0));
      check("t5_marker", q1[b+1], mk(2, 2'b00, 1));
    end

    // full FIFO: pop and push in the same cycle, then a genuine drop
    do_reset();
    out_ready = 1'b0;
    b = q1.size();
    stream(18, 2'b11, 0, 17, 1'b1, 17);
    tick(2);
    check("t3_dropped", dropped, 1);
    check("t3_busy_flush", busy, 1);
    out_ready = 1'b1;
    wait_idle(100);
    check("t3_count", q1.size() - b, 18);
    if (q1.size() - b >= 18) begin
      for (int i = 0; i < 17; i++) check("t3_rec", q1[b+i], mk(i, 2'b11, 0));
      check("t3_marker", q1[b+17], mk(18, 2'b00, 1));
    end

    // out_ready toggling with a report on every symbol
    do_reset();
    b  = q1.size();
    sb = stall_err;
    stream(30, 2'b11, 0, 29, 1'b1, -2);
    wait_idle(100);
    check("t4_count", q1.size() - b, 31);
    if (q1.size() - b >= 31) begin
      for (int i = 0; i < 30; i++) check("t4_rec", q1[b+i], mk(i, 2'b11, 0));
      check("t4_marker", q1[b+30], mk(30, 2'b00, 1));
    end
    check("t4_dropped", dropped, 0);
    check("t4_stable", stall_err - sb, 0);

    // offset wrap on the 4-bit build
    do_reset();
    out_ready = 1'b1;
    b = q2.size();
    stream(17, 2'b10, 15, 16, 1'b1, -1);
    wait_idle(100);
    tick(3);
    check("t6_count", q2.size() - b, 3);
    if (q2.size() - b >= 3) begin
      check("t6_rec15", q2[b], mk(15, 2'b10, 0));
      check("t6_rec_wrap", q2[b+1], mk(0, 2'b10, 0));
      check("t6_marker", q2[b+2], mk(1, 2'b00, 1));
    end
    check("stall_total", stall_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/report_collector.md
Name: report_collector

Overview:
- Sits directly downstream of an Automata_* instance and consumes its report outputs (active_state of the report STEs).
- Tags every cycle with at least one active report with the stream offset of the symbol that caused it.
- Buffers these records in a small FIFO and drains them over a valid/ready interface to the kernel's host-side writer.
- At end of stream it appends one end-marker record, so the host knows the report list for that stream is complete.

Parameters:
- NUM_REPORTS, 2, number of report bits taken from the automaton (one per report STE).
- OFFSET_W, 32, width of the symbol offset counter.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- DROP_W, 16, width of the dropped-record counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-low; the block is in reset when reset==0 at a clk edge.
- run  in  1  same run strobe driven to the automaton; a symbol is consumed in each cycle where run==1.
- eos  in  1  end-of-stream pulse, one cycle, asserted in the cycle after the last run==1 cycle.
- report_in  in  NUM_REPORTS  automaton report outputs; bit i = report STE i.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record when out_valid && out_ready.
- out_offset  out  OFFSET_W  offset of the reporting symbol; count of symbols for the end marker.
- out_vector  out  NUM_REPORTS  report bits of the record; all zero for the end marker.
- out_last  out  1  1 only on the end-marker record.
- overflow  out  1  sticky; set when any record was dropped.
- dropped  out  DROP_W  number of dropped records, saturating.
- busy  out  1  high in ACTIVE or FLUSH.

Behaviour:
- Reset (reset==0 at edge):
  - FIFO emptied; offset counter=0; FSM=IDLE.
  - out_valid=0, out_offset=0, out_vector=0, out_last=0, overflow=0, dropped=0, busy=0.
  - Applies mid-stream and mid-drain: all pending records are discarded and no end marker is emitted.
- Alignment:
  - The automaton registers STE state, so report_in in cycle t belongs to the symbol consumed in cycle t-1.
  - The block keeps run_q (run delayed one cycle) and off_q (offset delayed one cycle).
  - A record {off_q, report_in, last=0} is generated in cycle t iff run_q==1 and |report_in==1.
  - report_in is ignored when run_q==0.
- Offset counter: increments by 1 on each run==1 cycle and wraps modulo 2^OFFSET_W. The first symbol after reset has offset 0.
- FSM:
  - IDLE: busy=0. Go to ACTIVE on run==1.
  - ACTIVE: generate and push records. On eos==1 go to FLUSH. The record for the final symbol (run_q in the eos cycle) is still captured.
  - FLUSH: push end marker {offset=symbol count, vector=0, last=1}. If the FIFO is full, stay in FLUSH; the end marker is never dropped and the FSM retries each cycle. Once pushed, go to DONE.
  - DONE: busy=0. Go to ACTIVE on the next run==1 and clear the offset counter to 0 on that transition. overflow and dropped are not cleared; only reset clears them.
  - eos in IDLE or DONE is ignored.
- FIFO:
  - Registered-output, first-word-fall-through style; out_* reflect the head entry.
  - out_valid=1 iff non-empty. The first record reaches out_valid one cycle after it is generated.
  - out_offset, out_vector and out_last must stay stable while out_valid && !out_ready.
  - Simultaneous push and pop when full: the pop frees the slot and the push is accepted; no drop.
  - Simultaneous push and pop when empty: the record goes into the FIFO and out_valid rises next cycle; no bypass.
- Drop: a normal record generated while full with no pop in the same cycle is discarded. overflow<=1 and dropped increments, holding at 2^DROP_W-1.
- Throughput: one push and one pop per cycle sustained.

Test Plan:
1. Stream of 5 symbols with report_in=2'b01 aligned to the symbol at offset 3, out_ready=1, eos after the last symbol → records {3,01,0} then {5,00,1}; overflow=0.
2. report_in=2'b11 for symbols 0..19 with out_ready=0, DEPTH=16, then eos, then out_ready=1 → 16 records at offsets 0..15, dropped=4, overflow=1; end marker {20,00,1} delivered last after the FSM waited in FLUSH.
3. FIFO full, out_ready=1 and a new record generated in the same cycle → occupancy stays 16; dropped unchanged.
4. out_ready toggling 1-0-1 every cycle with reports on every symbol for 30 symbols → the output sequence equals the generated sequence in order, and data stays stable while stalled.
5. reset=0 for one cycle mid-stream with 3 records queued → next cycle out_valid=0, dropped=0, busy=0; a new stream restarts at offset 0.
6. Offset counter preloaded near wrap (OFFSET_W=4 build), reports at symbols 15 and 16 → out_offset values 15 then 0.
